// File: rtl/demux_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg
// Shared constants, state encoding and helpers for the blocks that feed the
// team's 1-to-32 demultiplexer.
//   NUM_CH    : number of demux channels (power of two)
//   SEL_W     : channel select width, log2(NUM_CH)
//   state_t   : burst sequencer FSM states
//   clamp_len : limits a requested burst length to NUM_CH bits
// ---------------------------------------------------------------------------
package demux_pkg;

   localparam int NUM_CH = 32;
   localparam int SEL_W  = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // A burst can never be longer than one lap of the channels, so anything
   // larger is treated as a full lap.
   function automatic logic [SEL_W:0] clamp_len(input logic [SEL_W:0] len);
      logic [SEL_W:0] max_len;
      max_len = (SEL_W+1)'(NUM_CH);
      if (len > max_len) begin
         return max_len;
      end
      return len;
   endfunction

endpackage

// File: rtl/demux_burst_sequencer_if.sv
// ---------------------------------------------------------------------------
// demux_burst_sequencer_if
// Bundles the upstream serial bit handshake and the demux drive bus.
//   s_valid / s_data / s_ready : upstream bit stream handshake
//   dmx_in / dmx_sel / dmx_valid : data bit, channel select and beat strobe
//                                  going to the demultiplexer
// Modports:
//   master : the environment (upstream source and demux sink)
//   slave  : the burst sequencer
// ---------------------------------------------------------------------------
interface demux_burst_sequencer_if #(
   parameter int SEL_W = demux_pkg::SEL_W
) ();

   logic             s_valid;
   logic             s_data;
   logic             s_ready;
   logic             dmx_in;
   logic [SEL_W-1:0] dmx_sel;
   logic             dmx_valid;

   modport master (
      output s_valid,
      output s_data,
      input  s_ready,
      input  dmx_in,
      input  dmx_sel,
      input  dmx_valid
   );

   modport slave (
      input  s_valid,
      input  s_data,
      output s_ready,
      output dmx_in,
      output dmx_sel,
      output dmx_valid
   );

endinterface

// File: rtl/demux_burst_sequencer.sv
// ---------------------------------------------------------------------------
// demux_burst_sequencer
// Accepts a serial bit stream and, for a programmed burst, steers each
// accepted bit to consecutive demux channels starting at base_sel, wrapping
// from the last channel back to channel 0.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   start      : one-cycle burst request, only honoured in IDLE
//   base_sel   : first channel of the burst (sampled with start)
//   burst_len  : number of bits in the burst, 0 ignored, >NUM_CH clamped
//   abort      : ends a running burst without a done pulse
//   bus        : slave side of the stream/demux interface
//   busy       : high while a burst is running or completing
//   done       : one-cycle pulse when a burst completes normally
// ---------------------------------------------------------------------------
module demux_burst_sequencer #(
   parameter int NUM_CH = demux_pkg::NUM_CH,
   parameter int SEL_W  = demux_pkg::SEL_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [SEL_W-1:0]         base_sel,
   input  logic [SEL_W:0]           burst_len,
   input  logic                     abort,
   demux_burst_sequencer_if.slave   bus,
   output logic                     busy,
   output logic                     done
);

   import demux_pkg::*;

   state_t           state_q,     state_d;
   logic [SEL_W-1:0] idx_q,       idx_d;
   logic [SEL_W:0]   rem_q,       rem_d;
   logic             dmx_in_q,    dmx_in_d;
   logic [SEL_W-1:0] dmx_sel_q,   dmx_sel_d;
   logic             dmx_valid_q, dmx_valid_d;
   logic             busy_q,      busy_d;
   logic             done_q,      done_d;
   logic [SEL_W:0]   len_clamped;

   assign len_clamped = clamp_len(burst_len);

   // Ready is the only combinational output; abort wins over any offered bit
   // and reset keeps upstream stalled even before the state register settles.
   assign bus.s_ready = (state_q == RUN) && !abort && !rst;

   // Next-state and next-output logic. The index counter relies on NUM_CH
   // being a power of two so the natural SEL_W-bit overflow is the wrap.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      rem_d       = rem_q;
      dmx_in_d    = 1'b0;
      dmx_sel_d   = dmx_sel_q;
      dmx_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && (len_clamped != '0)) begin
               state_d = RUN;
               idx_d   = base_sel;
               rem_d   = len_clamped;
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
            end else if (bus.s_valid) begin
               dmx_in_d    = bus.s_data;
               dmx_sel_d   = idx_q;
               dmx_valid_d = 1'b1;
               idx_d       = idx_q + 1'b1;
               rem_d       = rem_q - 1'b1;
               if (rem_q == (SEL_W+1)'(1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // All state and every status/demux output are registered here so the
   // demux sees glitch-free select and data lines.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         rem_q       <= '0;
         dmx_in_q    <= 1'b0;
         dmx_sel_q   <= '0;
         dmx_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         rem_q       <= rem_d;
         dmx_in_q    <= dmx_in_d;
         dmx_sel_q   <= dmx_sel_d;
         dmx_valid_q <= dmx_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.dmx_in    = dmx_in_q;
   assign bus.dmx_sel   = dmx_sel_q;
   assign bus.dmx_valid = dmx_valid_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: doc/demux_burst_sequencer.md
# demux_burst_sequencer

Upstream sequencer for the team's 1-to-32 demultiplexer. Accepts a serial bit stream over a valid/ready handshake and, for a programmed burst, steers each accepted bit to consecutive output channels by driving the demux data bit and 5-bit select. The channel index auto-increments with wrap-around. The block reports busy and done status to the control logic.

## Interface
Parameters:
- NUM_CH, 32, number of demux channels (power of two)
- SEL_W, 5, select width, log2(NUM_CH)

Ports:
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a burst; sampled only in IDLE
- base_sel  input  SEL_W  first channel of the burst; sampled with start
- burst_len  input  SEL_W+1  bits in the burst, 1..32; sampled with start
- abort  input  1  terminates a running burst
- s_valid  input  1  upstream bit valid
- s_data  input  1  upstream bit
- s_ready  output  1  block accepts a bit this cycle
- dmx_in  output  1  data bit to demux (registered)
- dmx_sel  output  SEL_W  channel select to demux (registered)
- dmx_valid  output  1  dmx_in/dmx_sel carry a bit this cycle (registered)
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse, burst completed normally

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 with burst_len in 1..32 → RUN; idx←base_sel, remaining←burst_len.
  - start with burst_len=0 is ignored, stays IDLE.
  - burst_len>32 is clamped to 32.
- RUN: s_ready = !abort (combinational). A bit is accepted when s_valid && s_ready. On acceptance:
  - dmx_in←s_data, dmx_sel←idx, dmx_valid←1
  - idx←idx+1 mod NUM_CH (31 wraps to 0)
  - remaining←remaining−1
  - If the accepted bit was the last (remaining==1) → DONE.
- Cycles in RUN without acceptance: dmx_valid←0, dmx_in←0, dmx_sel holds its value.
- abort in RUN:
  - Takes priority over a concurrent s_valid; that bit is not accepted.
  - Next state IDLE, dmx_valid←0, dmx_in←0, no done pulse.
- DONE: lasts exactly one cycle; done=1, then IDLE. start is ignored in DONE and in RUN.
- abort outside RUN has no effect.
- dmx_in is forced to 0 whenever dmx_valid=0, so the demux outputs are all zero between bits.

## Timing
- Reset values: state IDLE, dmx_in=0, dmx_sel=0, dmx_valid=0, busy=0, done=0. s_ready=0 during and after reset.
- rst mid-burst: IDLE on the next edge; the partial burst is discarded and done is not pulsed.
- start → RUN: 1 cycle. s_ready can first be high in the cycle after start.
- Accept → dmx outputs valid: 1 cycle latency. Throughput is 1 bit/cycle with s_valid held high.
- A burst of N bits with continuous s_valid:
  - Start cycle t: accepts in t+1..t+N, dmx_valid in t+2..t+N+1.
  - DONE/done=1 in t+N+1, the same cycle as the last dmx_valid.
  - IDLE in t+N+2, where the next start is accepted.
- busy rises the cycle after start and falls the cycle after done.
- s_ready is combinational from state and abort. All other outputs are registered.

## Structure
- Shared package demux_pkg:
  - NUM_CH, SEL_W constants
  - state enum {IDLE, RUN, DONE}
  - the burst_len clamp function, shared with future bursts feeding the demux
- Single module, no sub-module. The FSM, index counter and remaining counter are flat.
- The bench instantiates this block driving the 1-to-32 demultiplexer to check end-to-end channel outputs.

## Test plan
- Basic burst: base_sel=3, burst_len=4, s_data=1,0,1,1 continuous.
  - dmx_sel=3,4,5,6 on consecutive cycles with dmx_in=1,0,1,1.
  - done high with the sel=6 beat; busy falls the next cycle.
- Wrap-around: base_sel=30, burst_len=4.
  - dmx_sel sequence 30,31,0,1.
  - Demux outputs y[30],y[31],y[0],y[1] pulse in turn.
- Back-pressure: base_sel=0, burst_len=3, s_valid toggled 1,0,0,1,1.
  - Exactly 3 dmx_valid beats, sel 0,1,2.
  - dmx_in=0 and dmx_valid=0 in the gap cycles; done after the third beat.
- Abort collision: burst_len=8; abort asserted together with s_valid on the 3rd bit.
  - Third bit not accepted; only 2 dmx_valid beats.
  - No done pulse; IDLE next cycle; a new start is then accepted.
- Length edges: burst_len=0 → no busy; burst_len=32 from base_sel=5 → 32 beats covering every sel once, ending at 4; burst_len=40 → clamped to 32 beats.
- Reset mid-burst: rst asserted after 2 of 10 bits.
  - Next cycle all outputs at reset values, s_ready=0, no done.
  - start ignored during RUN/DONE: a second start mid-burst does not change base_sel or the count.
